// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, data width and default oversample ratio.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int UART_DATA_BITS = 8;
  // Also used by the tx baud generator so both ends agree on the tick rate.
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchronizer for an asynchronous level input; flops reset to 1 (idle line level).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver driven by an external oversample tick.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote over the ticks ending at each sample point.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      os_tick,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rxbyte,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_P = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_P = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e                 state, state_n;
  logic [CW-1:0]             tick_cnt, tick_n;
  logic [2:0]                bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] rxbyte_n;
  logic                      valid_n, ferr_n;
  logic                      armed, armed_n;
  logic                      sample;

`ifdef UART_RX_MAJORITY_EN
  // rx_s seen on the two previous os_ticks; with the current value this
  // forms the P-2, P-1, P window at any sample point.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (os_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rxbyte    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      rxbyte    <= rxbyte_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      armed     <= armed_n;
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    rxbyte_n = rxbyte;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
    armed_n  = armed;
    case (state)
      IDLE: begin
        // A tick arriving with the falling edge is deliberately not counted.
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_cnt == HALF_P) begin
            tick_n = '0;
            if (!sample) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + CW'(1);
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_cnt == FULL_P) begin
            shift_n = {sample, shift[UART_DATA_BITS-1:1]};
            tick_n  = '0;
            if (bit_idx == LAST_BIT) begin
              state_n = STOP;
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          if (tick_cnt == FULL_P) begin
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            if (sample) begin
              rxbyte_n = shift;
              valid_n  = 1'b1;
            end else begin
              ferr_n  = 1'b1;
              armed_n = 1'b0;
            end
            state_n = IDLE;
            tick_n  = '0;
          end else begin
            tick_n = tick_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 (OVERSAMPLE=16, os_tick every clk, one bit = 16 clk).
module tb_uart_rx_8n1;

  logic       clk;
  logic       rst_n;
  logic       os_tick;
  logic       rx;
  logic [7:0] rxbyte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_8n1 #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .os_tick   (os_tick),
    .rx        (rx),
    .rxbyte    (rxbyte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected events: bit 8 = frame error, bits 7:0 = byte for a good frame.
  logic [8:0] exp_q[$];
  logic [7:0] last_good;
  int         valid_cnt;
  int         ferr_cnt;
  logic       prev_valid;
  logic       prev_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a byte is received as sent unless a one-clk glitch lands on the
  // mid-bit sample of a data bit; a single-sample receiver takes it, a majority one rejects it.
  function automatic logic [7:0] model_byte(input logic [7:0] b, input int glitch_clk);
    logic [7:0] r;
    r = b;
`ifndef UART_RX_MAJORITY_EN
    if (glitch_clk >= 16 && glitch_clk < 144 && (glitch_clk % 16) == 8)
      r[glitch_clk / 16 - 1] = ~r[glitch_clk / 16 - 1];
`endif
    return r;
  endfunction

  // Drive nclk clocks of a frame {stop, data, start}; optionally invert one clk.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int nclk,
                             input int glitch_clk);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (nclk == 160) exp_q.push_back(stop ? {1'b0, model_byte(b, glitch_clk)} : {1'b1, 8'h00});
    for (int j = 0; j < nclk; j++) begin
      @(negedge clk);
      rx = f[j / 16] ^ (j == glitch_clk);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (rx_valid || frame_err) begin
        check("excl", {31'd0, rx_valid & frame_err}, 32'd0);
        check("pulse_width", {31'd0, (rx_valid & prev_valid) | (frame_err & prev_ferr)}, 32'd0);
        check("expected_pulse", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("event_kind", {31'd0, frame_err}, {31'd0, e[8]});
          if (!e[8]) last_good = e[7:0];
          check(e[8] ? "byte_kept" : "rxbyte", {24'd0, rxbyte}, {24'd0, last_good});
        end
        if (rx_valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
      end
      prev_valid = rx_valid;
      prev_ferr  = frame_err;
    end
  end

  initial begin
    int busy_cnt;
    int v0, f0;
    logic [7:0] b;
    logic       s;
    rst_n = 1'b0;
    rx = 1'b1;
    os_tick = 1'b1;
    last_good = 8'h00;
    valid_cnt = 0;
    ferr_cnt = 0;
    prev_valid = 1'b0;
    prev_ferr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rxbyte", {24'd0, rxbyte}, 32'd0);
    check("rst_flags", {29'd0, rx_valid, frame_err, busy}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // 1: single frame
    v0 = valid_cnt;
    drive_frame(8'hA5, 1'b1, 160, -1);
    idle(20);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    check("t1_rxbyte", {24'd0, rxbyte}, 32'hA5);
    check("t1_busy", {31'd0, busy}, 0);

    // 2: back-to-back
    v0 = valid_cnt;
    drive_frame(8'h00, 1'b1, 160, -1);
    drive_frame(8'hFF, 1'b1, 160, -1);
    idle(20);
    check("t2_valid_cnt", valid_cnt - v0, 2);
    check("t2_rxbyte", {24'd0, rxbyte}, 32'hFF);

    // 3: short low glitch on an idle line
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("t3_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    check("t3_busy_len", {31'd0, busy_cnt >= 1 && busy_cnt <= 9}, 1);
    check("t3_idle", {31'd0, busy}, 0);

    // 4: framing error then break, then recovery
    f0 = ferr_cnt;
    v0 = valid_cnt;
    drive_frame(8'h3C, 1'b0, 160, -1);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("t4_ferr_cnt", ferr_cnt - f0, 1);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_byte_kept", {24'd0, rxbyte}, 32'hFF);
    idle(20);
    drive_frame(8'h81, 1'b1, 160, -1);
    idle(20);
    check("t4_recover", {24'd0, rxbyte}, 32'h81);

    // 5: reset mid-frame (during data bit 3)
    v0 = valid_cnt;
    drive_frame(8'h5A, 1'b1, 70, -1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_out", {23'd0, rxbyte, rx_valid, frame_err, busy}, 0);
    rx = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("t5_no_pulse", valid_cnt - v0, 0);
    drive_frame(8'h5A, 1'b1, 160, -1);
    idle(20);
    check("t5_rxbyte", {24'd0, rxbyte}, 32'h5A);

    // 6: one-clk glitch at the sample point of data bit 2
    drive_frame(8'hF0, 1'b1, 160, 3 * 16 + 8);
    idle(20);
`ifdef UART_RX_MAJORITY_EN
    check("t6_glitch", {24'd0, rxbyte}, 32'hF0);
`else
    check("t6_glitch", {24'd0, rxbyte}, 32'hF4);
`endif

    // random frames, occasional framing errors, random gaps
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      drive_frame(b, s, 160, -1);
      idle(s ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end
    idle(20);
    check("rand_rxbyte", {24'd0, rxbyte}, {24'd0, last_good});
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
